// File: rtl/serial_pattern_detector.sv
// Serial bit-stream pattern detector with a fill-tracking control FSM, a one-cycle
// match pulse and a saturating match counter. Overlapping matches are selectable.
module serial_pattern_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PAT_W-1:0]   hist_r;
    logic [PAT_W-1:0]   hist_nxt_s;
    logic [PAT_W-1:0]   hist_shift_s;
    logic [FILL_W-1:0]  fill_r;
    logic [FILL_W-1:0]  fill_nxt_s;
    logic [FILL_W-1:0]  fill_inc_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               match_r;
    logic               match_nxt_s;
    logic               armed_r;
    logic               armed_nxt_s;
    logic               sample_s;
    logic               match_evt_s;
    logic               flush_s;

    // Sampling qualifiers, candidate history/fill and match event detection
    always_comb begin
        sample_s     = bit_vld & ~clr;
        hist_shift_s = {hist_r[PAT_W-2:0], bit_in};
        if (fill_r == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_r + FILL_ONE;
        end
        match_evt_s = sample_s && (fill_inc_s == FILL_FULL) && (hist_shift_s == PATTERN);
        flush_s     = match_evt_s && (OVERLAP == 1'b0);
    end

    // Next history and fill count; a non-overlapping match flushes both
    always_comb begin
        hist_nxt_s = hist_r;
        fill_nxt_s = fill_r;
        if (clr) begin
            hist_nxt_s = {PAT_W{1'b0}};
            fill_nxt_s = {FILL_W{1'b0}};
        end else if (sample_s) begin
            if (flush_s) begin
                hist_nxt_s = {PAT_W{1'b0}};
                fill_nxt_s = {FILL_W{1'b0}};
            end else begin
                hist_nxt_s = hist_shift_s;
                fill_nxt_s = fill_inc_s;
            end
        end else begin
            hist_nxt_s = hist_r;
            fill_nxt_s = fill_r;
        end
    end

    // Control FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (clr) begin
            state_nxt_s = IDLE;
        end else if (!sample_s) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = FILL;
                FILL: begin
                    if (fill_inc_s != FILL_FULL) begin
                        state_nxt_s = FILL;
                    end else if (flush_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                ARMED: begin
                    if (flush_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Output logic: match pulse, saturating counter, armed flag
    always_comb begin
        match_nxt_s = match_evt_s;
        armed_nxt_s = (state_nxt_s == ARMED);
        cnt_nxt_s   = cnt_r;
        if (clr) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (match_evt_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            hist_r  <= {PAT_W{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            match_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            hist_r  <= hist_nxt_s;
            fill_r  <= fill_nxt_s;
            cnt_r   <= cnt_nxt_s;
            match_r <= match_nxt_s;
            armed_r <= armed_nxt_s;
        end
    end

    assign match     = match_r;
    assign match_cnt = cnt_r;
    assign armed     = armed_r;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Randomised and directed bench for serial_pattern_detector: three instances
// (overlapping, non-overlapping, 2-bit counter) checked against a bit-queue model.
module tb_serial_pattern_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_vld;
    logic       clr;
    logic       m0, m1, m2;
    logic       a0, a1, a2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: recent sampled bits since last clear/flush, per instance
    bit         mq[3][$];
    int         cnt_m[3];
    bit         match_m[3];
    int         cmax[3] = '{255, 255, 3};
    bit         ovl[3]  = '{1'b1, 1'b0, 1'b1};
    logic [3:0] pat     = 4'b1011;

    always #5 clk = ~clk;

    serial_pattern_detector u_dut_ovl (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
        .match(m0), .match_cnt(c0), .armed(a0)
    );

    serial_pattern_detector #(.OVERLAP(1'b0)) u_dut_novl (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
        .match(m1), .match_cnt(c1), .armed(a1)
    );

    serial_pattern_detector #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
        .match(m2), .match_cnt(c2), .armed(a2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, " ovl.match"},  32'(m0), 32'(match_m[0]));
        check_eq({tag, " ovl.cnt"},    32'(c0), 32'(cnt_m[0]));
        check_eq({tag, " ovl.armed"},  32'(a0), 32'(mq[0].size() == 4));
        check_eq({tag, " novl.match"}, 32'(m1), 32'(match_m[1]));
        check_eq({tag, " novl.cnt"},   32'(c1), 32'(cnt_m[1]));
        check_eq({tag, " novl.armed"}, 32'(a1), 32'(mq[1].size() == 4));
        check_eq({tag, " sat.match"},  32'(m2), 32'(match_m[2]));
        check_eq({tag, " sat.cnt"},    32'(c2), 32'(cnt_m[2]));
        check_eq({tag, " sat.armed"},  32'(a2), 32'(mq[2].size() == 4));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            cnt_m[i]   = 0;
            match_m[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit b, input bit v, input bit c);
        bit hit;
        for (int i = 0; i < 3; i++) begin
            match_m[i] = 1'b0;
            if (c) begin
                mq[i].delete();
                cnt_m[i] = 0;
            end else if (v) begin
                mq[i].push_back(b);
                if (mq[i].size() > 4) void'(mq[i].pop_front());
                hit = (mq[i].size() == 4);
                for (int k = 0; k < 4; k++) begin
                    if (mq[i].size() == 4 && mq[i][k] != pat[3-k]) hit = 1'b0;
                end
                if (hit) begin
                    match_m[i] = 1'b1;
                    if (cnt_m[i] < cmax[i]) cnt_m[i]++;
                    if (!ovl[i]) mq[i].delete();
                end
            end
        end
    endtask

    task automatic step(input bit b, input bit v, input bit c, input string tag);
        bit_in  = b;
        bit_vld = v;
        clr     = c;
        @(posedge clk);
        model_step(b, v, c);
        #1;
        check_all(tag);
    endtask

    // asynchronous reset asserted between edges, checked before any clock edge
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst     = 1'b0;
        bit_vld = 1'b0;
        clr     = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input string tag);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, 1'b0, tag);
    endtask

    initial begin
        rst     = 1'b0;
        bit_in  = 1'b0;
        bit_vld = 1'b0;
        clr     = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // overlap stream 1011011
        send_bits(32'b1011011, 7, "overlap");
        step(1'b0, 1'b0, 1'b0, "overlap idle");

        // gapped valid
        do_reset("rst2");
        for (int i = 3; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b0, "gap bit");
            for (int g = 0; g < 3; g++) step(1'($urandom), 1'b0, 1'b0, "gap hold");
        end

        // partial fill guard
        do_reset("rst3");
        send_bits(32'b011, 3, "partial");

        // clear priority with five matches registered
        do_reset("rst4");
        send_bits(32'b1011011011011011, 16, "pre-clr");
        step(1'b1, 1'b1, 1'b1, "clr+vld");
        send_bits(32'b1011, 4, "post-clr");

        // saturation and mid-pattern reset
        do_reset("rst5");
        send_bits(32'b1011011011011011011, 19, "sat");
        send_bits(32'b101, 3, "mid");
        do_reset("rst mid");
        step(1'b1, 1'b1, 1'b0, "after rst");

        // randomised traffic
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) begin
                do_reset("rnd rst");
            end else begin
                step(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 59) == 0), "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
